mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage access controller, directly downstream of the EX/MEM pipeline latch and upstream of the MEM/WB latch.
- Consumes EX/MEM outputs and runs the data-memory handshake, including the two-access LDI/STI indirection.
- Drives the global stall_pipeline while an access is outstanding.
- Presents registered load data to writeback, plus a stall-cycle performance counter.

Parameters:
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high, sampled on posedge clk
- mem_read_in  in  1  EX/MEM: instruction reads memory (LDR/LDB/LDI/TRAP vector fetch)
- mem_write_in  in  1  EX/MEM: instruction writes memory (STR/STB/STI)
- is_ldi_in  in  1  EX/MEM: LDI indirection
- is_sti_in  in  1  EX/MEM: STI indirection
- addr_sel_in  in  2  00 alu_out_in, 01 addr_adder_out_in, 10 trapvector_in, 11 alu_out_in
- alu_out_in  in  16  lc3b_word
- addr_adder_out_in  in  16  lc3b_word
- trapvector_in  in  16  lc3b_word, already zero-extended and shifted
- dest_data_in  in  16  store data
- mem_byte_enable_in  in  2  11 word, 01 low byte, 10 high byte
- dmem_address  out  16  data-memory address
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_byte_enable  out  2  write lanes
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- mem_data_out  out  16  registered load result to MEM/WB
- stall_pipeline  out  1  freezes all pipeline latches
- stall_count  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Request: req = mem_read_in | mem_write_in. EX/MEM is frozen by stall_pipeline, so its inputs stay stable for the whole access.
- States:
  - IDLE: no access issued.
    - req=1: next FIRST; stall_pipeline=1 combinationally this cycle.
    - req=0: stall_pipeline=0; the instruction flows through with no penalty.
  - FIRST: dmem_address = selected address.
    - LDI, STI, or mem_read: dmem_read=1.
    - Plain store: dmem_write=1.
    - On dmem_resp, plain op: capture the lane-processed rdata into mem_data_out (loads only); next DONE.
    - On dmem_resp, LDI/STI: capture rdata into ptr_reg; next INDIRECT.
  - INDIRECT: dmem_address = ptr_reg.
    - LDI: dmem_read=1. STI: dmem_write=1, byte_enable 11, wdata dest_data_in.
    - On dmem_resp: LDI captures rdata into mem_data_out; next DONE.
  - DONE: stall_pipeline=0 for exactly one cycle so EX/MEM and MEM/WB advance; next IDLE.
- stall_pipeline = (IDLE & req) | FIRST | INDIRECT.
- dmem_read and dmem_write are never both 1. Both are 0 in IDLE and DONE.
- Byte lanes:
  - Byte load: select rdata[7:0] if byte_enable=01, rdata[15:8] if 10; zero-extend to 16.
  - Byte store: dmem_wdata = {dest_data_in[7:0], dest_data_in[7:0]}, dmem_byte_enable = mem_byte_enable_in.
  - Word ops: byte_enable 11, wdata = dest_data_in unmodified.
- Latency: a plain access with an N-cycle memory takes N+2 cycles from instruction arrival to advance. LDI/STI take N1+N2+2 cycles.
- mem_data_out holds its value until the next load capture. Stores and non-memory instructions leave it unchanged.
- dmem_resp while in IDLE or DONE is ignored.
- Both mem_read_in and mem_write_in with neither is_ldi nor is_sti: treated as a read.
- stall_count increments every cycle stall_pipeline=1 and saturates at all-ones (no wrap).
- Reset, including mid-access:
  - state IDLE, ptr_reg 0, mem_data_out 0x0000, stall_count 0.
  - Strobes are decoded from state, so they are 0 from the cycle after rst is sampled.
  - A dmem_resp arriving after reset is ignored.

Decomposition:
- lc3b_types (shared package):
  - lc3b_word.
  - Enum lc3b_mem_state {IDLE, FIRST, INDIRECT, DONE}.
  - addr_sel encodings as named constants.
  - Byte-enable constants (BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10).
- Sub-module mem_lane_align: combinational load zero-extend/select and store replicate.
- FSM, address mux, registers and counter stay in mem_stage_access.

Test Plan:
- Non-memory instruction: req=0 → stall_pipeline=0 every cycle; no dmem strobes; stall_count stays 0.
- LDR: addr_sel=00, alu_out=0x3000, memory returns 0xBEEF after 3 cycles → dmem_read with address 0x3000 for 3 cycles; stall=1 for 4 cycles; DONE; mem_data_out=0xBEEF; stall_count=4.
- LDB high byte: address 0x3001, byte_enable=10, rdata 0xA55A → mem_data_out=0x00A5.
- STB: dest_data=0x1234, byte_enable=01 → dmem_write, wdata=0x3434, dmem_byte_enable=01; mem_data_out unchanged.
- LDI: first access at 0x4000 returns 0x5000; second access at 0x5000 returns 0x0042 → two dmem_read phases with correct addresses; mem_data_out=0x0042. STI variant: write 0x0099 to 0x5000, byte_enable 11.
- Reset during INDIRECT, with dmem_resp arriving one cycle after rst → state IDLE; strobes 0; mem_data_out=0; late resp ignored. Separately, 2^CNT_WIDTH+5 stall cycles → stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word, MEM-stage state and encoding constants
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, FIRST, INDIRECT, DONE} lc3b_mem_state;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_ADDER = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;
  localparam logic [1:0] SEL_ALU_ALT = 2'b11;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
endpackage

// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if: data-memory request/response bus
interface mem_stage_access_if;
  import lc3b_types::*;
  lc3b_word address;
  lc3b_word wdata;
  lc3b_word rdata;
  logic read;
  logic write;
  logic resp;
  logic [1:0] byte_enable;
  modport master(output address, read, write, byte_enable, wdata, input rdata, resp);
  modport slave(input address, read, write, byte_enable, wdata, output rdata, resp);
endinterface

// File: rtl/mem_stage_access_lane.sv
// mem_lane_align: byte-lane select/zero-extend for loads, replicate for stores
module mem_lane_align
  import lc3b_types::*;
(
  input  logic [1:0] byte_enable,
  input  lc3b_word   rdata,
  input  lc3b_word   wdata,
  output lc3b_word   load_data,
  output lc3b_word   store_data
);
  always_comb load_data = byte_enable == BE_LO ? {8'h00, rdata[7:0]} :
                          byte_enable == BE_HI ? {8'h00, rdata[15:8]} : rdata;
  always_comb store_data = byte_enable == BE_WORD ? wdata : {2{wdata[7:0]}};
endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory handshake with LDI/STI indirection and stall counter
module mem_stage_access
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 is_ldi_in,
  input  logic                 is_sti_in,
  input  logic [1:0]           addr_sel_in,
  input  lc3b_word             alu_out_in,
  input  lc3b_word             addr_adder_out_in,
  input  lc3b_word             trapvector_in,
  input  lc3b_word             dest_data_in,
  input  logic [1:0]           mem_byte_enable_in,
  mem_stage_access_if.master   dmem,
  output lc3b_word             mem_data_out,
  output logic                 stall_pipeline,
  output logic [CNT_WIDTH-1:0] stall_count
);
  lc3b_mem_state state, state_next;
  lc3b_word ptr_reg, addr, load_data, store_data;
  logic req, ind, first_rd;
  assign req = mem_read_in | mem_write_in;
  assign ind = is_ldi_in | is_sti_in;
  assign first_rd = ind | mem_read_in;
  always_comb addr = addr_sel_in == SEL_ADDER ? addr_adder_out_in :
                     addr_sel_in == SEL_TRAP ? trapvector_in : alu_out_in;
  mem_lane_align u_align (
    .byte_enable(mem_byte_enable_in),
    .rdata      (dmem.rdata),
    .wdata      (dest_data_in),
    .load_data  (load_data),
    .store_data (store_data)
  );
  always_comb begin
    state_next = state;
    stall_pipeline = 1'b0;
    dmem.address = addr;
    dmem.read = 1'b0;
    dmem.write = 1'b0;
    dmem.byte_enable = BE_WORD;
    dmem.wdata = dest_data_in;
    unique case (state)
      IDLE: begin
        stall_pipeline = req;
        state_next = req ? FIRST : IDLE;
      end
      FIRST: begin
        stall_pipeline = 1'b1;
        dmem.read = first_rd;
        dmem.write = ~first_rd;
        dmem.byte_enable = mem_byte_enable_in;
        dmem.wdata = store_data;
        state_next = !dmem.resp ? FIRST : ind ? INDIRECT : DONE;
      end
      INDIRECT: begin
        stall_pipeline = 1'b1;
        dmem.address = ptr_reg;
        dmem.read = is_ldi_in;
        dmem.write = ~is_ldi_in;
        state_next = dmem.resp ? DONE : INDIRECT;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr_reg <= '0;
      mem_data_out <= '0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      if (state == FIRST && dmem.resp && ind) ptr_reg <= dmem.rdata;
      if (state == FIRST && dmem.resp && !ind && mem_read_in) mem_data_out <= load_data;
      if (state == INDIRECT && dmem.resp && is_ldi_in) mem_data_out <= dmem.rdata;
      if (stall_pipeline && !(&stall_count)) stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: randomized transactions checked against a per-instruction reference model
module tb_mem_stage_access;
  logic clk = 1'b0;
  logic rst;
  logic mem_read_in, mem_write_in, is_ldi_in, is_sti_in;
  logic [1:0] addr_sel_in, mem_byte_enable_in;
  logic [15:0] alu_out_in, addr_adder_out_in, trapvector_in, dest_data_in;
  logic [15:0] mem_data_out;
  logic stall_pipeline;
  logic [15:0] stall_count;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_data;
  int m_stall;
  mem_stage_access_if dmem ();
  mem_stage_access #(.CNT_WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .is_ldi_in         (is_ldi_in),
    .is_sti_in         (is_sti_in),
    .addr_sel_in       (addr_sel_in),
    .alu_out_in        (alu_out_in),
    .addr_adder_out_in (addr_adder_out_in),
    .trapvector_in     (trapvector_in),
    .dest_data_in      (dest_data_in),
    .mem_byte_enable_in(mem_byte_enable_in),
    .dmem              (dmem),
    .mem_data_out      (mem_data_out),
    .stall_pipeline    (stall_pipeline),
    .stall_count       (stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    mem_read_in = 0; mem_write_in = 0; is_ldi_in = 0; is_sti_in = 0;
    addr_sel_in = 0; mem_byte_enable_in = 2'b11;
    alu_out_in = 0; addr_adder_out_in = 0; trapvector_in = 0; dest_data_in = 0;
  endtask
  // One memory access lasting n cycles; the response pulses on the last one.
  task automatic phase(input string tag, input logic [15:0] a, input bit rd, input logic [1:0] be,
                       input logic [15:0] wd, input int n, input logic [15:0] rdata);
    for (int i = 0; i < n; i++) begin
      dmem.resp = (i == n - 1);
      dmem.rdata = (i == n - 1) ? rdata : 16'($urandom);
      @(negedge clk);
      if (i < 3 || i == n - 1) begin
        chk({tag, "_stall"}, stall_pipeline, 1);
        chk({tag, "_addr"}, dmem.address, a);
        chk({tag, "_rd"}, dmem.read, rd);
        chk({tag, "_wr"}, dmem.write, !rd);
        if (!rd) begin
          chk({tag, "_be"}, dmem.byte_enable, be);
          chk({tag, "_wdata"}, dmem.wdata, wd);
        end
      end
      tick();
      dmem.resp = 0;
    end
  endtask
  task automatic run_op(input bit rd, input bit wr, input bit ldi, input bit sti, input logic [1:0] sel,
                        input logic [15:0] alu, input logic [15:0] adder, input logic [15:0] trap,
                        input logic [15:0] d, input logic [1:0] be, input int n1, input int n2,
                        input logic [15:0] r1, input logic [15:0] r2);
    bit ind;
    logic [15:0] a;
    mem_read_in = rd; mem_write_in = wr; is_ldi_in = ldi; is_sti_in = sti;
    addr_sel_in = sel; alu_out_in = alu; addr_adder_out_in = adder; trapvector_in = trap;
    dest_data_in = d; mem_byte_enable_in = be;
    dmem.resp = 1'($urandom);
    dmem.rdata = 16'($urandom);
    @(negedge clk);
    chk("idle_stall", stall_pipeline, rd | wr);
    chk("idle_rd", dmem.read, 0);
    chk("idle_wr", dmem.write, 0);
    tick();
    dmem.resp = 0;
    if (rd | wr) begin
      ind = ldi | sti;
      a = sel == 2'd1 ? adder : sel == 2'd2 ? trap : alu;
      phase("first", a, ind | rd, be, be == 2'b11 ? d : (d & 16'h00FF) * 16'h0101, n1, r1);
      m_stall += 1 + n1;
      if (ind) begin
        phase("indirect", r1, ldi, 2'b11, d, n2, r2);
        m_stall += n2;
      end
      dmem.resp = 1'($urandom);
      @(negedge clk);
      chk("done_stall", stall_pipeline, 0);
      chk("done_rd", dmem.read, 0);
      chk("done_wr", dmem.write, 0);
      tick();
      dmem.resp = 0;
      if (ldi) m_data = r2;
      else if (!ind && rd) m_data = be == 2'b01 ? r1 % 256 : be == 2'b10 ? r1 / 256 : r1;
    end
    clear_inputs();
    chk("data_out", mem_data_out, m_data);
    chk("stall_count", stall_count, m_stall > 65535 ? 65535 : m_stall);
  endtask
  initial begin
    int kind;
    bit byte_op;
    logic [1:0] be;
    rst = 1;
    clear_inputs();
    dmem.resp = 0;
    dmem.rdata = 0;
    m_data = 0;
    m_stall = 0;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_data", mem_data_out, 0);
    chk("rst_count", stall_count, 0);
    chk("rst_stall", stall_pipeline, 0);
    chk("rst_rd", dmem.read, 0);
    chk("rst_wr", dmem.write, 0);
    tick();
    // Non-memory instructions
    for (int i = 0; i < 3; i++) run_op(0, 0, 0, 0, 0, 16'h1111, 0, 0, 16'h2222, 2'b11, 1, 1, 0, 0);
    run_op(1, 0, 0, 0, 2'b00, 16'h3000, 16'h7777, 16'h8888, 0, 2'b11, 3, 1, 16'hBEEF, 0);
    chk("ldr_data", mem_data_out, 16'hBEEF);
    chk("ldr_count", stall_count, 4);
    run_op(1, 0, 0, 0, 2'b01, 0, 16'h3001, 0, 0, 2'b10, 2, 1, 16'hA55A, 0);
    chk("ldb_hi", mem_data_out, 16'h00A5);
    run_op(0, 1, 0, 0, 2'b00, 16'h3002, 0, 0, 16'h1234, 2'b01, 1, 1, 16'hFFFF, 0);
    chk("stb_keep", mem_data_out, 16'h00A5);
    run_op(1, 0, 1, 0, 2'b00, 16'h4000, 0, 0, 0, 2'b11, 2, 3, 16'h5000, 16'h0042);
    chk("ldi_data", mem_data_out, 16'h0042);
    run_op(0, 1, 0, 1, 2'b01, 0, 16'h4000, 0, 16'h0099, 2'b11, 1, 2, 16'h5000, 16'hDEAD);
    chk("sti_keep", mem_data_out, 16'h0042);
    run_op(1, 0, 0, 0, 2'b10, 0, 0, 16'h0040, 0, 2'b11, 1, 1, 16'h1200, 0);
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 7);
      byte_op = (kind == 2 || kind == 4);
      be = byte_op ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b11;
      run_op(kind inside {1, 2, 5, 7}, kind inside {3, 4, 6, 7}, kind == 5, kind == 6,
             2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), be,
             $urandom_range(1, 4), $urandom_range(1, 4), 16'($urandom), 16'($urandom));
    end
    // Reset while the indirect access is outstanding, then a stale response
    mem_read_in = 1; is_ldi_in = 1; alu_out_in = 16'h4000;
    tick();
    dmem.resp = 1; dmem.rdata = 16'h5000;
    tick();
    dmem.resp = 0;
    @(negedge clk);
    chk("pre_rst_addr", dmem.address, 16'h5000);
    chk("pre_rst_rd", dmem.read, 1);
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
    dmem.resp = 1; dmem.rdata = 16'h1111;
    @(negedge clk);
    chk("mid_rst_rd", dmem.read, 0);
    chk("mid_rst_wr", dmem.write, 0);
    chk("mid_rst_stall", stall_pipeline, 0);
    chk("mid_rst_data", mem_data_out, 0);
    chk("mid_rst_count", stall_count, 0);
    tick();
    dmem.resp = 0;
    @(negedge clk);
    chk("late_resp_data", mem_data_out, 0);
    chk("late_resp_rd", dmem.read, 0);
    tick();
    m_data = 0;
    m_stall = 0;
    run_op(1, 0, 0, 0, 2'b00, 16'h6000, 0, 0, 0, 2'b11, 65541, 1, 16'h0F0F, 0);
    chk("sat_count", stall_count, 16'hFFFF);
    run_op(0, 1, 0, 0, 2'b00, 16'h6002, 0, 0, 16'h5555, 2'b11, 2, 1, 0, 0);
    chk("sat_hold", stall_count, 16'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
